// File: rtl/pipe_adder_if.sv
// rtl/pipe_adder_if.sv - operand/result handshake bundle for pipe_adder
interface pipe_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined adder/subtractor with one registered carry per chunk
// Stage k adds chunk k; operands ride along so each beat's bits leave together.
module pipe_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic        clk,
   input  logic        rst,
   pipe_adder_if.slave bus
);
   localparam int CW = WIDTH / STAGES;

   if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipe_adder: WIDTH must be a positive multiple of STAGES");
   end

   logic             valid_q [STAGES];
   logic             valid_d [STAGES];
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] a_d     [STAGES];
   logic [WIDTH-1:0] bp_q    [STAGES];
   logic [WIDTH-1:0] bp_d    [STAGES];
   logic [WIDTH-1:0] s_q     [STAGES];
   logic [WIDTH-1:0] s_d     [STAGES];
   logic             c_q     [STAGES];
   logic             c_d     [STAGES];
   logic             ovf_q;
   logic             ovf_d;

   logic             src_v   [STAGES];
   logic [WIDTH-1:0] src_a   [STAGES];
   logic [WIDTH-1:0] src_bp  [STAGES];
   logic [WIDTH-1:0] src_s   [STAGES];
   logic             src_c   [STAGES];
   logic [CW:0]      chunk_w [STAGES];
   logic             adv;

   // One global enable: the whole pipe either shifts or holds.
   assign adv = !valid_q[STAGES-1] || bus.out_ready;

   always_comb begin
      src_v[0]  = bus.in_valid;
      src_a[0]  = bus.a;
      src_bp[0] = bus.sub ? ~bus.b : bus.b;
      src_s[0]  = '0;
      src_c[0]  = bus.sub ? 1'b1 : bus.cin;
      for (int k = 1; k < STAGES; k++) begin
         src_v[k]  = valid_q[k-1];
         src_a[k]  = a_q[k-1];
         src_bp[k] = bp_q[k-1];
         src_s[k]  = s_q[k-1];
         src_c[k]  = c_q[k-1];
      end
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         chunk_w[k] = {1'b0, src_a[k][k*CW +: CW]}
                    + {1'b0, src_bp[k][k*CW +: CW]}
                    + {{CW{1'b0}}, src_c[k]};
      end
   end

   // Data registers load only under a valid beat, so bubbles leave outputs untouched.
   always_comb begin
      ovf_d = ovf_q;
      for (int k = 0; k < STAGES; k++) begin
         valid_d[k] = valid_q[k];
         a_d[k]     = a_q[k];
         bp_d[k]    = bp_q[k];
         s_d[k]     = s_q[k];
         c_d[k]     = c_q[k];
         if (adv) begin
            valid_d[k] = src_v[k];
            if (src_v[k]) begin
               a_d[k]               = src_a[k];
               bp_d[k]              = src_bp[k];
               s_d[k]               = src_s[k];
               s_d[k][k*CW +: CW]   = chunk_w[k][CW-1:0];
               c_d[k]               = chunk_w[k][CW];
            end
         end
      end
      if (adv && src_v[STAGES-1]) begin
         ovf_d = (src_a[STAGES-1][WIDTH-1] == src_bp[STAGES-1][WIDTH-1])
              && (s_d[STAGES-1][WIDTH-1] != src_a[STAGES-1][WIDTH-1]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            a_q[k]     <= '0;
            bp_q[k]    <= '0;
            s_q[k]     <= '0;
            c_q[k]     <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= valid_d[k];
            a_q[k]     <= a_d[k];
            bp_q[k]    <= bp_d[k];
            s_q[k]     <= s_d[k];
            c_q[k]     <= c_d[k];
         end
         ovf_q <= ovf_d;
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = valid_q[STAGES-1];
   assign bus.sum       = s_q[STAGES-1];
   assign bus.cout      = c_q[STAGES-1];
   assign bus.ovf       = ovf_q;
endmodule
